// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
//
// Shared definitions for the RV32I multicycle control path. The main control
// FSM and the downstream ALU control decoder both import this package, so the
// encodings of ALUOp, ALUSrcA/B, MemtoReg and PCSource live here.
//
// Contents:
//   mc_state_e  - main control FSM states (also exposed as the debug 'state')
//   OPC_*       - major opcodes dispatched on in DECODE
//   ALUOP_*     - ALUOp encodings seen by the ALU control decoder
//   SRCA_* / SRCB_* / WB_* / PCSRC_* - datapath mux select encodings
//   mc_ctrl_t   - bundle of all datapath control outputs
//   isMemOpcode - true for load/store major opcodes
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } mc_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic [1:0] memtoReg;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } mc_ctrl_t;

    function automatic logic isMemOpcode(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
//
// Purely combinational state -> datapath-control decoder for the multicycle
// main control FSM. Everything is a Moore decode of the state except the
// FETCH-cycle IR/PC write strobes, which fire only in the cycle memory
// actually returns the instruction.
//
// Ports:
//   state_i      in   current FSM state
//   mem_ready_i  in   memory completes the current access this cycle
//   ctrl_o       out  all datapath enables and mux selects
//
// Configuration: MC_ILLEGAL_TRAP_EN adds the TRAP state decode (all zero).
// ---------------------------------------------------------------------------
module mc_ctrl_decode
    import rv_ctrl_pkg::*;
(
    input  mc_state_e state_i,
    input  logic      mem_ready_i,
    output mc_ctrl_t  ctrl_o
);

    // Start every state from all-zero so each arm lists only what it asserts;
    // anything not mentioned for a state stays deasserted.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.memRead = 1'b1;
                ctrl_o.iorD    = 1'b0;
                ctrl_o.aluSrcA = SRCA_PC;
                ctrl_o.aluSrcB = SRCB_FOUR;
                ctrl_o.aluOp   = ALUOP_ADD;
                // IR capture and PC+4 update only when the fetch completes,
                // so a stalled fetch never corrupts the PC.
                ctrl_o.irWrite  = mem_ready_i;
                ctrl_o.pcWrite  = mem_ready_i;
                ctrl_o.pcSource = PCSRC_ALU;
            end
            S_DECODE: begin
                // Speculative branch/jump target (oldPC + imm) into ALUOut.
                ctrl_o.aluSrcA = SRCA_OLDPC;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.aluSrcA = SRCA_RS1;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.memRead = 1'b1;
                ctrl_o.iorD    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memtoReg = WB_MDR;
            end
            S_MEMWR: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.iorD     = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.aluSrcA = SRCA_RS1;
                ctrl_o.aluSrcB = SRCB_RS2;
                ctrl_o.aluOp   = ALUOP_RFUNCT;
            end
            S_EXEC_I: begin
                ctrl_o.aluSrcA = SRCA_RS1;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_IFUNCT;
            end
            S_ALUWB: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memtoReg = WB_ALUOUT;
            end
            S_BRANCH: begin
                // rs1 - rs2; the zero flag qualifies PCWriteCond and the
                // target computed in DECODE comes from ALUOut.
                ctrl_o.aluSrcA     = SRCA_RS1;
                ctrl_o.aluSrcB     = SRCB_RS2;
                ctrl_o.aluOp       = ALUOP_SUB;
                ctrl_o.pcWriteCond = 1'b1;
                ctrl_o.pcSource    = PCSRC_ALUOUT;
            end
            S_JAL: begin
                // Link register gets the already-incremented PC while the PC
                // takes the jump target held in ALUOut.
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memtoReg = WB_PC;
                ctrl_o.pcWrite  = 1'b1;
                ctrl_o.pcSource = PCSRC_ALUOUT;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                ctrl_o = '0;
            end
`endif
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// ---------------------------------------------------------------------------
// mc_main_ctrl
//
// Multicycle main control FSM for the RV32I core. Each instruction walks
// FETCH -> DECODE -> (execute/memory) -> write-back, with FETCH, MEMRD and
// MEMWR stalling on the shared memory's ready handshake.
//
// Parameters:
//   ILLEGAL_OPC_Q  1: 'illegal' stays set until reset once the FSM traps.
//
// Configuration macro:
//   MC_ILLEGAL_TRAP_EN  defined   - unknown opcode parks the FSM in TRAP until
//                                   reset, 'illegal' asserted, not retired.
//                       undefined - unknown opcode retires as a NOP with a
//                                   one-cycle 'illegal' pulse (in the cycle
//                                   after DECODE); TRAP is never entered.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   opcode         instruction register bits [6:0]
//   mem_ready      memory completes the current access this cycle
//   PCWrite .. RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource
//                  datapath controls (decoded by mc_ctrl_decode)
//   illegal        unknown opcode seen
//   instret        retired-instruction count (wraps)
//   state          current FSM state, for debug
// ---------------------------------------------------------------------------
module mc_main_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_OPC_Q = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [3:0]  state
);

    mc_state_e   state_q;
    mc_state_e   state_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        illegal_q;
    logic        illegal_d;
    logic        illegalSeen;
    logic        retire;
    mc_ctrl_t    ctrl;

    // Next-state logic. mem_ready only matters in the three memory-access
    // states; everywhere else the FSM advances unconditionally.
    always_comb begin
        state_d     = state_q;
        illegalSeen = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OPC_LOAD,
                    OPC_STORE:  state_d = S_MEMADR;
                    OPC_RTYPE:  state_d = S_EXEC_R;
                    OPC_ITYPE:  state_d = S_EXEC_I;
                    OPC_BRANCH: state_d = S_BRANCH;
                    OPC_JAL:    state_d = S_JAL;
                    default: begin
                        illegalSeen = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                state_d = (opcode == OPC_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R,
            S_EXEC_I: begin
                state_d = S_ALUWB;
            end
            S_ALUWB,
            S_BRANCH,
            S_JAL: begin
                state_d = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // An instruction retires exactly when the FSM re-enters FETCH from any
    // other state; a stalled FETCH does not count. The adder wraps naturally.
    always_comb begin
        retire    = (state_d == S_FETCH) && (state_q != S_FETCH);
        instret_d = instret_q + {31'd0, retire};
    end

    // 'illegal' is raised by the dispatch that saw the unknown opcode. Only
    // the TRAP state can keep it set, so in the NOP build it is a single
    // cycle pulse.
    always_comb begin
        illegal_d = illegalSeen
                  | (ILLEGAL_OPC_Q && illegal_q && (state_q == S_TRAP));
    end

    // State, retire counter and illegal flag. Reset is asynchronous so the
    // decoded write enables drop as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    mc_ctrl_decode uDecode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign PCWrite     = ctrl.pcWrite;
    assign PCWriteCond = ctrl.pcWriteCond;
    assign IorD        = ctrl.iorD;
    assign MemRead     = ctrl.memRead;
    assign MemWrite    = ctrl.memWrite;
    assign IRWrite     = ctrl.irWrite;
    assign RegWrite    = ctrl.regWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign ALUSrcB     = ctrl.aluSrcB;
    assign ALUOp       = ctrl.aluOp;
    assign PCSource    = ctrl.pcSource;
    assign illegal     = illegal_q;
    assign instret     = instret_q;
    assign state       = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_main_ctrl
//
// Scoreboard bench for mc_main_ctrl. The stimulus side walks whole
// instructions through an instruction-level model (which phases an opcode
// visits, how many stall cycles memory inserts, when instret bumps) and
// queues the expected per-cycle outputs; a monitor pops one entry every
// falling edge and compares it with the DUT.
//
// Honours MC_ILLEGAL_TRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mc_main_ctrl;
    import rv_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic        ill;
        logic [31:0] ir;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0]  MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state;

    exp_t        expQ[$];
    int          checks;
    int          errors;
    logic [31:0] modelCount;
    logic        illFlag;
    logic        trapped;
    logic        preloadNext;

    mc_main_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .illegal     (illegal),
        .instret     (instret),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-phase control word as a literal table:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,
    //  MemtoReg,ALUSrcA,ALUSrcB,ALUOp,PCSource}
    function automatic logic [16:0] expCtrl(input mc_state_e s, input logic r);
        case (s)
            S_FETCH:  return {r, 1'b0, 1'b0, 1'b1, 1'b0, r, 1'b0, 10'b00_00_01_00_00};
            S_DECODE: return {7'b0000000, 10'b00_10_10_00_00};
            S_MEMADR: return {7'b0000000, 10'b00_01_10_00_00};
            S_MEMRD:  return {7'b0011000, 10'b00_00_00_00_00};
            S_MEMWB:  return {7'b0000001, 10'b01_00_00_00_00};
            S_MEMWR:  return {7'b0010100, 10'b00_00_00_00_00};
            S_EXEC_R: return {7'b0000000, 10'b00_01_00_10_00};
            S_EXEC_I: return {7'b0000000, 10'b00_01_10_11_00};
            S_ALUWB:  return {7'b0000001, 10'b00_00_00_00_00};
            S_BRANCH: return {7'b0100000, 10'b00_01_00_01_01};
            S_JAL:    return {7'b1000001, 10'b10_00_00_00_01};
            default:  return 17'b0;
        endcase
    endfunction

    function automatic int opClass(input logic [6:0] opc);
        case (opc)
            7'b0000011: return 0;
            7'b0100011: return 1;
            7'b0110011: return 2;
            7'b0010011: return 3;
            7'b1100011: return 4;
            7'b1101111: return 5;
            default:    return 6;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one clock cycle of inputs and queue what the DUT should show.
    task automatic applyStimulus(input logic rstn, input logic rdy,
                                 input logic [6:0] opc, input mc_state_e s);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rstn;
        mem_ready = rdy;
        opcode    = opc;
        if (preloadNext) begin
            force dut.instret_q = 32'hFFFF_FFFF;
            #1;
            release dut.instret_q;
            modelCount  = 32'hFFFF_FFFF;
            preloadNext = 1'b0;
        end
        e.st   = s;
        e.ctrl = expCtrl(s, rdy);
        e.ill  = illFlag;
        e.ir   = modelCount;
        expQ.push_back(e);
        if (!trapped) illFlag = 1'b0;
    endtask

    task automatic doReset(input int n, input logic [6:0] opc);
        modelCount = '0;
        illFlag    = 1'b0;
        trapped    = 1'b0;
        repeat (n) applyStimulus(1'b0, 1'b1, opc, S_FETCH);
    endtask

    // One whole instruction: wf stalls in FETCH, wm stalls in MEMRD/MEMWR.
    task automatic runInstr(input logic [6:0] opc, input int wf, input int wm);
        repeat (wf) applyStimulus(1'b1, 1'b0, opc, S_FETCH);
        applyStimulus(1'b1, 1'b1, opc, S_FETCH);
        applyStimulus(1'b1, rnd(), opc, S_DECODE);
        case (opClass(opc))
            0: begin
                applyStimulus(1'b1, rnd(), opc, S_MEMADR);
                repeat (wm) applyStimulus(1'b1, 1'b0, opc, S_MEMRD);
                applyStimulus(1'b1, 1'b1, opc, S_MEMRD);
                applyStimulus(1'b1, rnd(), opc, S_MEMWB);
                modelCount = modelCount + 32'd1;
            end
            1: begin
                applyStimulus(1'b1, rnd(), opc, S_MEMADR);
                repeat (wm) applyStimulus(1'b1, 1'b0, opc, S_MEMWR);
                applyStimulus(1'b1, 1'b1, opc, S_MEMWR);
                modelCount = modelCount + 32'd1;
            end
            2: begin
                applyStimulus(1'b1, rnd(), opc, S_EXEC_R);
                applyStimulus(1'b1, rnd(), opc, S_ALUWB);
                modelCount = modelCount + 32'd1;
            end
            3: begin
                applyStimulus(1'b1, rnd(), opc, S_EXEC_I);
                applyStimulus(1'b1, rnd(), opc, S_ALUWB);
                modelCount = modelCount + 32'd1;
            end
            4: begin
                applyStimulus(1'b1, rnd(), opc, S_BRANCH);
                modelCount = modelCount + 32'd1;
            end
            5: begin
                applyStimulus(1'b1, rnd(), opc, S_JAL);
                modelCount = modelCount + 32'd1;
            end
            default: begin
                illFlag = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
                trapped = 1'b1;
                repeat (4) applyStimulus(1'b1, rnd(), opc, S_TRAP);
                doReset(2, opc);
`else
                modelCount = modelCount + 32'd1;
`endif
            end
        endcase
    endtask

    task automatic checkOutput(input exp_t e);
        logic [16:0] actCtrl;
        actCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                   MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource};
        checks++;
        if (state !== e.st) begin
            errors++;
            $display("[TB] FAIL state: got %0d want %0d at %0t", state, e.st, $time);
        end
        checks++;
        if (actCtrl !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL ctrl: got %b want %b (state %0d) at %0t", actCtrl, e.ctrl, e.st, $time);
        end
        checks++;
        if (illegal !== e.ill) begin
            errors++;
            $display("[TB] FAIL illegal: got %b want %b at %0t", illegal, e.ill, $time);
        end
        checks++;
        if (instret !== e.ir) begin
            errors++;
            $display("[TB] FAIL instret: got %h want %h at %0t", instret, e.ir, $time);
        end
    endtask

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        logic [6:0] opc;
        int         sel;
        checks      = 0;
        errors      = 0;
        modelCount  = '0;
        illFlag     = 1'b0;
        trapped     = 1'b0;
        preloadNext = 1'b0;
        rst_n       = 1'b0;
        mem_ready   = 1'b1;
        opcode      = OPC_RTYPE;

        doReset(3, OPC_RTYPE);
        runInstr(OPC_RTYPE, 0, 0);
        runInstr(OPC_LOAD, 2, 2);
        runInstr(OPC_BRANCH, 0, 0);
        runInstr(OPC_STORE, 1, 1);
        runInstr(OPC_ITYPE, 0, 0);
        runInstr(OPC_JAL, 0, 0);
        runInstr(7'b1111111, 0, 0);
        runInstr(OPC_RTYPE, 0, 0);

        // Reset pulse while a store is stalled in MEMWR.
        runInstr(OPC_ITYPE, 0, 0);
        applyStimulus(1'b1, 1'b1, OPC_STORE, S_FETCH);
        applyStimulus(1'b1, rnd(), OPC_STORE, S_DECODE);
        applyStimulus(1'b1, rnd(), OPC_STORE, S_MEMADR);
        applyStimulus(1'b1, 1'b0, OPC_STORE, S_MEMWR);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL resetMemWrite: got %b want 0", MemWrite);
        end
        checks++;
        if (state !== 4'(S_FETCH)) begin
            errors++;
            $display("[TB] FAIL resetState: got %0d want %0d", state, S_FETCH);
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++;
            $display("[TB] FAIL resetInstret: got %h want 0", instret);
        end
        doReset(1, OPC_STORE);

        // instret wrap through a retiring JAL.
        runInstr(OPC_RTYPE, 0, 0);
        preloadNext = 1'b1;
        runInstr(OPC_JAL, 0, 0);
        runInstr(OPC_BRANCH, 0, 0);

        // Randomised instruction stream with random memory stalls.
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: opc = OPC_LOAD;
                1: opc = OPC_STORE;
                2: opc = OPC_RTYPE;
                3: opc = OPC_ITYPE;
                4: opc = OPC_BRANCH;
                5: opc = OPC_JAL;
                default: opc = 7'($urandom_range(0, 127));
            endcase
            runInstr(opc, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        runInstr(OPC_RTYPE, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d entries left want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
